mem_port_arbiter: RTL and testbench

//  Shares the single-port unified memory between the IF stage (instruction fetch)
//  and the MEM stage (lw/sw). Sequences every access as grant -> wait-ready ->

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Arbitrates the single-port unified memory between instruction
//                fetch and load/store. Each access runs grant -> wait-ready ->
//                respond. The block returns read data, raises pipeline stall
//                requests and pulses write_done when a store completes.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              write_done,
  // pipeline stall requests
  output logic              pc_stall,
  output logic              mem_stall,
  // memory port
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  // sticky timeout flag
  output logic              err
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_owner_d;   // 1 = current access belongs to the data port
  logic             r_last_d;    // 1 = most recent grant went to the data port

  logic w_any_req;
  logic w_grant_d;
  logic w_timeout;

  // Data normally wins; fetch wins when data had the previous grant, so a
  // stream of loads/stores can never starve instruction fetch.
  assign w_any_req = if_req | d_req;
  assign w_grant_d = d_req & ~(r_last_d & if_req);
  assign w_timeout = (r_timer == TMR_LAST) & ~m_ready;

  // Sequencer: owner selection, wait timer and state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_owner_d <= 1'b0;
      r_last_d  <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner_d <= w_grant_d;
            r_last_d  <= w_grant_d;
            r_timer   <= '0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (m_ready) begin
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            err     <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory port: launch on grant, hold steady through WAIT, drop enable on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            m_en    <= 1'b1;
            m_we    <= w_grant_d & d_we;
            m_addr  <= w_grant_d ? d_addr : if_addr;
            m_wdata <= w_grant_d ? d_wdata : '0;
          end else begin
            m_en <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (m_ready || w_timeout) begin
            m_en <= 1'b0;
          end
        end
        default: begin
          m_en <= 1'b0;
        end
      endcase
    end
  end

  // Read-data capture: stores keep d_rdata, an aborted access returns zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (r_state == ST_WAIT) begin
      if (m_ready) begin
        if (!r_owner_d) begin
          if_rdata <= m_rdata;
        end else if (!m_we) begin
          d_rdata <= m_rdata;
        end
      end else if (w_timeout) begin
        if (r_owner_d) begin
          d_rdata <= '0;
        end else begin
          if_rdata <= '0;
        end
      end
    end
  end

  // Acks last exactly the RESP cycle; m_we still reflects the finished access.
  assign if_ack     = (r_state == ST_RESP) & ~r_owner_d;
  assign d_ack      = (r_state == ST_RESP) & r_owner_d;
  assign write_done = d_ack & m_we;
  assign pc_stall   = if_req & ~if_ack;
  assign mem_stall  = d_req & ~d_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench: directed vector table, randomized
//                transactions against a transaction-level model, reset abort.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 8;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        write_done;
  logic        pc_stall;
  logic        mem_stall;
  logic        m_en;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_ready;
  logic        err;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .write_done(write_done),
    .pc_stall(pc_stall), .mem_stall(mem_stall),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One batch: requests raised together, each held until its own ack.
  // lat = WAIT cycles with m_ready low before m_ready is given.
  typedef struct {
    bit          f_req;
    logic [15:0] f_addr;
    int          f_lat;
    logic [15:0] f_mdata;
    bit          d_req;
    bit          d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    int          d_lat;
    logic [15:0] d_mdata;
    bit          exp_first_d;
    logic [15:0] exp_if_rdata;
    logic [15:0] exp_d_rdata;
    bit          exp_wd;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // transaction-level model state
  bit          m_last_d = 1'b0;
  bit          m_err    = 1'b0;
  logic [15:0] m_if     = 16'h0;
  logic [15:0] m_d      = 16'h0;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int acc_len(input int lat);
    return (lat + 1 < TIMEOUT) ? lat + 1 : TIMEOUT;
  endfunction

  function automatic vec_t mk_exp(input vec_t v);
    vec_t r;
    r = v;
    r.exp_first_d  = v.d_req && !(m_last_d && v.f_req);
    r.exp_if_rdata = !v.f_req ? m_if : ((v.f_lat >= TIMEOUT) ? 16'h0 : v.f_mdata);
    r.exp_d_rdata  = (!v.d_req || v.d_we) ? m_d : ((v.d_lat >= TIMEOUT) ? 16'h0 : v.d_mdata);
    r.exp_wd       = v.d_req && v.d_we;
    return r;
  endfunction

  // Called just after a rising edge with the DUT idle; returns likewise.
  task automatic run_vec(input vec_t v);
    bit pend_f, pend_d, own_d, ack_now, en_now;
    int t_en, t_ack, lat, cyc;
    if_req  = v.f_req;  if_addr = v.f_addr;
    d_req   = v.d_req;  d_we    = v.d_we;
    d_addr  = v.d_addr; d_wdata = v.d_wdata;
    m_ready = 1'b0;
    pend_f  = v.f_req;
    pend_d  = v.d_req;
    own_d   = (v.f_req && v.d_req) ? v.exp_first_d : v.d_req;
    t_en    = 1;
    lat     = own_d ? v.d_lat : v.f_lat;
    t_ack   = t_en + acc_len(lat);
    cyc     = 0;
    #1;
    while ((pend_f || pend_d) && cyc < 400) begin
      ack_now = (cyc == t_ack);
      en_now  = (cyc >= t_en) && (cyc < t_ack);
      if (ack_now && (lat >= TIMEOUT)) m_err = 1'b1;
      chk("m_en", m_en, en_now);
      chk("if_ack", if_ack, ack_now && !own_d);
      chk("d_ack", d_ack, ack_now && own_d);
      chk("write_done", write_done, ack_now && own_d && v.exp_wd);
      chk("pc_stall", pc_stall, pend_f && !(ack_now && !own_d));
      chk("mem_stall", mem_stall, pend_d && !(ack_now && own_d));
      chk("err", err, m_err);
      if (en_now) begin
        chk("m_addr", m_addr, own_d ? v.d_addr : v.f_addr);
        chk("m_we", m_we, own_d && v.d_we);
        chk("m_wdata", m_wdata, own_d ? v.d_wdata : 16'h0);
      end
      if (ack_now) begin
        if (own_d) chk("d_rdata", d_rdata, v.exp_d_rdata);
        else       chk("if_rdata", if_rdata, v.exp_if_rdata);
      end
      // memory responder; m_ready outside WAIT is noise the DUT must ignore
      if (en_now && (cyc - t_en) == lat) begin
        m_ready = 1'b1;
        m_rdata = own_d ? v.d_mdata : v.f_mdata;
      end else begin
        m_ready = en_now ? 1'b0 : 1'($urandom_range(0, 1));
        m_rdata = 16'($urandom);
      end
      if (ack_now) begin
        if (own_d) begin pend_d = 1'b0; d_req = 1'b0; end
        else       begin pend_f = 1'b0; if_req = 1'b0; end
        m_last_d = own_d;
        if (pend_f || pend_d) begin
          own_d = !own_d;
          t_en  = cyc + 2;
          lat   = own_d ? v.d_lat : v.f_lat;
          t_ack = t_en + acc_len(lat);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (pend_f || pend_d) begin
      failures++;
      $display("FAIL batch_timeout: requests still pending after %0d cycles", cyc);
    end
    if_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    m_if = v.exp_if_rdata;
    m_d  = v.exp_d_rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   k;
    rst_n = 1'b0; if_req = 1'b0; if_addr = 16'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 16'h0; d_wdata = 16'h0; m_rdata = 16'h0; m_ready = 1'b0;

    // f_req f_addr f_lat f_mdata | d_req d_we d_addr d_wdata d_lat d_mdata | first_d if_rd d_rd wd
    vecs[0]  = '{1, 16'h0010, 0, 16'hA5C3, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'hA5C3, 16'h0000, 0};
    vecs[1]  = '{0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0200, 16'h1234, 2, 16'hDEAD, 1, 16'hA5C3, 16'h0000, 1};
    vecs[2]  = '{0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0300, 16'h0000, 1, 16'hBEEF, 1, 16'hA5C3, 16'hBEEF, 0};
    vecs[3]  = '{1, 16'h0020, 0, 16'h1111, 1, 0, 16'h0400, 16'h0000, 1, 16'h2222, 0, 16'h1111, 16'h2222, 0};
    vecs[4]  = '{1, 16'h0030, 3, 16'h3333, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h3333, 16'h2222, 0};
    vecs[5]  = '{1, 16'h0040, 2, 16'h4444, 1, 1, 16'h0500, 16'h5555, 0, 16'h6666, 1, 16'h4444, 16'h2222, 1};
    vecs[6]  = '{1, 16'h0048, 1, 16'h4848, 1, 0, 16'h0510, 16'h0000, 2, 16'h5151, 1, 16'h4848, 16'h5151, 0};
    vecs[7]  = '{0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0600, 16'h0000, 99, 16'h7777, 1, 16'h4848, 16'h0000, 0};
    vecs[8]  = '{1, 16'h0050, 99, 16'h8888, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0};
    vecs[9]  = '{0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0700, 16'h0000, 7, 16'h9999, 1, 16'h0000, 16'h9999, 0};
    vecs[10] = '{1, 16'h0060, 6, 16'h6060, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h6060, 16'h9999, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_en", m_en, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_write_done", write_done, 0);
    chk("rst_err", err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    for (int n = 0; n < 60; n++) begin
      k         = $urandom_range(1, 3);
      v.f_req   = k[0];
      v.d_req   = k[1];
      v.f_addr  = 16'($urandom);
      v.f_lat   = $urandom_range(0, 9);
      v.f_mdata = 16'($urandom);
      v.d_we    = 1'($urandom_range(0, 1));
      v.d_addr  = 16'($urandom);
      v.d_wdata = 16'($urandom);
      v.d_lat   = v.d_we ? $urandom_range(0, 5) : $urandom_range(0, 9);
      v.d_mdata = 16'($urandom);
      v = mk_exp(v);
      run_vec(v);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("idle_m_en", m_en, 0);
      end
    end

    // asynchronous reset in the middle of a WAIT
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0800; d_wdata = 16'h0; m_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_m_en", m_en, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_m_en", m_en, 0);
    chk("arst_m_addr", m_addr, 0);
    chk("arst_d_ack", d_ack, 0);
    chk("arst_if_ack", if_ack, 0);
    chk("arst_err", err, 0);
    chk("arst_d_rdata", d_rdata, 0);
    chk("arst_if_rdata", if_rdata, 0);
    d_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_last_d = 1'b0; m_err = 1'b0; m_if = 16'h0; m_d = 16'h0;
    @(posedge clk); #1;
    // last-grant history is cleared by reset, so data wins the tie
    v = '{1, 16'h0090, 0, 16'hF00D, 1, 0, 16'h0900, 16'h0000, 1, 16'hC0DE, 1, 16'hF00D, 16'hC0DE, 0};
    run_vec(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
